// File: rtl/eval_latency_sm.sv
// Fixed-latency valid tracker: raises eval_valid LATENCY_COUNT clocks after a
// board_valid launch and holds it until clear_eval or a new launch.
module eval_latency_sm #(
    parameter int LATENCY_COUNT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic board_valid,
    input  logic clear_eval,
    output logic eval_valid
);

    localparam int CW = $clog2(LATENCY_COUNT + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(LATENCY_COUNT - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    if (LATENCY_COUNT < 1) begin : g_bad_latency
        $error("eval_latency_sm: LATENCY_COUNT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            eval_valid_q, eval_valid_d;

    // A launch outranks a clear, so a fresh board is never lost to a stale ack.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (board_valid) begin
            state_d = ST_WAIT;
            count_d = COUNT_LOAD;
        end else if (clear_eval) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (count_q == '0) begin
                        state_d = ST_VALID;
                    end else begin
                        count_d = count_q - COUNT_ONE;
                    end
                end
                ST_VALID: state_d = ST_VALID;
                ST_IDLE:  state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
        // Registered from the next state so the output has no input-to-output path.
        eval_valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            eval_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            eval_valid_q <= eval_valid_d;
        end
    end

    assign eval_valid = eval_valid_q;

endmodule

// File: tb/tb_eval_latency_sm.sv
// Bench for eval_latency_sm: L=7 and L=1 instances driven in parallel, checked
// against vector tables, directed sequences and a launch-time reference model.
module tb_eval_latency_sm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic board_valid = 1'b0;
    logic clear_eval = 1'b0;
    logic ev7, ev1;

    int tests = 0;
    int fails = 0;

    // Reference model: remembers the edge of the most recent live launch.
    int  ecnt = 0;
    bit  pend = 1'b0;
    int  launch_edge = 0;

    always #5 clk = ~clk;

    eval_latency_sm #(.LATENCY_COUNT(7)) dut7 (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .clear_eval(clear_eval), .eval_valid(ev7)
    );

    eval_latency_sm #(.LATENCY_COUNT(1)) dut1 (
        .clk(clk), .reset(reset), .board_valid(board_valid),
        .clear_eval(clear_eval), .eval_valid(ev1)
    );

    typedef struct {
        logic rst;
        logic bv;
        logic ce;
        logic e7;
        logic e1;
    } vec_t;

    vec_t vecs[20];

    function automatic logic model_exp(input int lat);
        return pend && ((ecnt - launch_edge) >= lat);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %b, want %b", name, ecnt, act, exp);
        end
    endtask

    // Drive one edge's inputs, advance the model, and sample 1 time unit after the edge.
    task automatic step(input logic r, input logic bv, input logic ce, input bit chk_model);
        reset = r;
        board_valid = bv;
        clear_eval = ce;
        @(posedge clk);
        ecnt++;
        if (!r) begin
            pend = 1'b0;
        end else if (bv) begin
            pend = 1'b1;
            launch_edge = ecnt;
        end else if (ce) begin
            pend = 1'b0;
        end
        #1;
        if (chk_model) begin
            check("model_L7", ev7, model_exp(7));
            check("model_L1", ev1, model_exp(1));
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].bv, vecs[i].ce, 1'b0);
            check($sformatf("vec%0d_L7", i), ev7, vecs[i].e7);
            check($sformatf("vec%0d_L1", i), ev1, vecs[i].e1);
        end

        // Basic latency: L7 stays low for six edges, rises on the seventh, then holds.
        idle_n(3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            check("basic_low", ev7, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("basic_rise", ev7, 1'b1);
        idle_n(23);
        check("basic_hold", ev7, 1'b1);

        // Launch during VALID drops the output and restarts the full latency.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("relaunch_drop", ev7, 1'b0);
        idle_n(6);
        check("relaunch_still_low", ev7, 1'b0);
        idle_n(1);
        check("relaunch_rise", ev7, 1'b1);

        // Back-to-back-ish launches: only the later one counts.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(3);
        check("restart_no_early", ev7, 1'b0);
        idle_n(3);
        check("restart_low_L-1", ev7, 1'b0);
        idle_n(1);
        check("restart_rise", ev7, 1'b1);

        // Clear mid-wait aborts the launch for good.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(2);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle_n(10);
        check("clear_abort", ev7, 1'b0);

        // Reset mid-wait aborts; the next launch then runs cleanly.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle_n(10);
        check("reset_abort", ev7, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(7);
        check("post_reset_rise", ev7, 1'b1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic r, bv, ce;
            r  = ($urandom_range(0, 99) >= 2);
            bv = ($urandom_range(0, 99) < 8);
            ce = ($urandom_range(0, 99) < 6);
            step(r, bv, ce, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eval_latency_sm.md
# eval_latency_sm

Fixed-latency valid tracker for the evaluation pipelines. It sits beside a fixed-depth datapath, such as the board evaluators. It watches the `board_valid` strobe that launches a board into the pipeline and raises `eval_valid` exactly `LATENCY_COUNT` clocks later, when the pipeline's registered result is stable. `eval_valid` then stays high until the consumer issues `clear_eval` or a new board is launched. The block has no datapath of its own: it is a counter plus a 3-state FSM.

## Interface
- `LATENCY_COUNT`, default 1: pipeline depth in clocks.
  - Legal range is ≥1; 0 is a configuration error.
  - The evaluators use 7.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset port. Reset is synchronous and active-low.
- `board_valid`  in  1  single-cycle strobe that launches a new board into the pipeline. The port is level-sampled every edge.
- `clear_eval`  in  1  the consumer has taken the result; drop `eval_valid`.
- `eval_valid`  out  1  registered output: the pipeline output for the most recent launch is valid.

## Operation
- State `count`: `$clog2(LATENCY_COUNT+1)` bits, unsigned.
- FSM states are IDLE, WAIT and VALID.
- `eval_valid` = (state == VALID), taken from a register with no combinational path from the inputs.
- Per rising edge, the first matching rule wins:
  1. `reset`==0 → state IDLE, `count` 0, `eval_valid` 0.
  2. `board_valid`==1, in any state → state WAIT, `count` ← `LATENCY_COUNT`−1, `eval_valid` 0.
     - A new launch restarts the count. An in-flight or held result is discarded.
     - `board_valid` beats `clear_eval` when both are high.
  3. `clear_eval`==1 → state IDLE, `count` 0. This aborts WAIT and drops VALID.
  4. In WAIT with `count`==0 → VALID.
  5. In WAIT with `count`≠0 → `count` decrements by 1.
  6. In VALID → hold; `eval_valid` stays 1 indefinitely.
  7. In IDLE → hold.
- `count` never wraps: it only decrements when nonzero.
- `clear_eval` in IDLE is a no-op.
- Inputs are treated as synchronous to `clk`; there is no synchroniser.

## Timing
- Reset values: `eval_valid`=0, state IDLE, `count`=0. These hold from the first edge sampled with `reset`=0 until the first edge after `reset` returns to 1.
- Latency: if `board_valid` is sampled 1 at edge N and no later `board_valid`, `clear_eval` or reset occurs, then:
  - `eval_valid` is 0 through edge N+`LATENCY_COUNT`−1;
  - `eval_valid` rises after edge N+`LATENCY_COUNT`.
- With `LATENCY_COUNT`=7, `board_valid` at edge 0 gives `eval_valid` high after edge 7. This matches a result register updated at edge 7.
- With `LATENCY_COUNT`=1, `eval_valid` is high the cycle after the launch edge.
- `clear_eval` at edge M → `eval_valid` low after edge M (one-cycle turnaround).
- `board_valid` at edge M while VALID → `eval_valid` low after edge M; high again after edge M+`LATENCY_COUNT`.
- Back-to-back `board_valid` on consecutive edges: only the last strobe counts. `eval_valid` rises `LATENCY_COUNT` edges after the last one.
- Reset low mid-WAIT or in VALID aborts immediately; the next launch restarts cleanly.

## Test plan
- Reset: hold `reset`=0 for 3 edges with `board_valid`=1 → `eval_valid`=0 throughout, and 0 on the first edge after release.
- Basic latency (`LATENCY_COUNT`=7): `board_valid` pulse at edge 10 → `eval_valid`=0 through edge 16, 1 after edge 17, still 1 at edge 40 with no `clear_eval`.
- Clear: with `eval_valid`=1, `clear_eval` at edge 20 → `eval_valid`=0 after edge 20; a `clear_eval` at edge 25 keeps it 0.
- Restart: `board_valid` at edges 0 and 4 (L=7) → `eval_valid`=0 after edge 7, 1 after edge 11. Also: `board_valid` during VALID at edge 30 → 0 after edge 30, 1 after edge 37.
- Priority: `board_valid` and `clear_eval` both high at edge 50 → WAIT entered, `eval_valid` 1 after edge 57. `clear_eval` alone at edge 53 of a new wait → no rise at edge 57+.
- Boundary: instance with `LATENCY_COUNT`=1 → `board_valid` at edge 5 gives `eval_valid`=1 after edge 6. Reset low at edge 3 of a L=7 wait → `eval_valid` never rises for that launch.
